// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM word RAM that stalls every transfer WAIT_CYCLES cycles, with a preload port
//   clk, reset        : single clock, asynchronous active-high reset (clears state and every memory word)
//   address, read, write, writedata, byteenable : Avalon-MM slave request from the CPU master
//   waitrequest, readdata : Avalon-MM stall and read data (readdata is zero outside read-completing cycles)
//   inst_input, inst_addr, instruction : full-word preload port, wins over a bus write to the same word
//   protocol_err      : sticky flag raised when read and write are seen together in IDLE
module avalon_wait_ram #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   input  logic        inst_input,
   input  logic [7:0]  inst_addr,
   input  logic [31:0] instruction,
   output logic        protocol_err
);
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   // The IDLE accept cycle already stalls once, so the counter holds the remaining stall cycles.
   localparam logic [3:0] LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [31:0] mem [DEPTH_WORDS];
   logic [5:0] idx, pidx;
   logic one_req, stall, ack, rd_ack, wr_ack, unused_bits;
   assign idx = address[7:2];
   assign pidx = inst_addr[7:2];
   assign one_req = read ^ write;
   assign unused_bits = ^{address[31:8], address[1:0], inst_addr[1:0]};
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      stall = 1'b0;
      ack = 1'b0;
      case (state)
         IDLE:
            if (one_req && inst_input) stall = 1'b1;
            else if (one_req && WAIT_CYCLES == 0) ack = 1'b1;
            else if (one_req) begin
               stall = 1'b1;
               cnt_nx = LOAD;
               state_nx = (WAIT_CYCLES == 1) ? ACK : WAIT;
            end
         WAIT: begin
            stall = 1'b1;
            cnt_nx = cnt - 4'd1;
            state_nx = (cnt <= 4'd1) ? ACK : WAIT;
         end
         ACK: begin
            ack = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // Outputs drop the moment reset rises, without waiting for the state register.
   assign waitrequest = stall & ~reset;
   // A master that drops or doubles its request mid-WAIT gets an empty ACK.
   assign rd_ack = ack & read & ~write & ~reset;
   assign wr_ack = ack & write & ~read;
   assign readdata = rd_ack ? mem[idx] : 32'd0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= 4'd0;
         protocol_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (state == IDLE && read && write) protocol_err <= 1'b1;
      end
   end
   // Preload is written last so it overrides a bus write to the same word on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else begin
         if (wr_ack)
            for (int b = 0; b < 4; b++)
               if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         if (inst_input) mem[pidx] <= instruction;
      end
   end
endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram: directed bench for avalon_wait_ram (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance)
module tb_avalon_wait_ram;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] address, writedata, instruction;
   logic read, write, inst_input;
   logic [3:0] byteenable;
   logic [7:0] inst_addr;
   logic waitrequest, protocol_err, waitrequest0, protocol_err0;
   logic [31:0] readdata, readdata0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   avalon_wait_ram #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
      .readdata(readdata), .inst_input(inst_input), .inst_addr(inst_addr),
      .instruction(instruction), .protocol_err(protocol_err)
   );

   avalon_wait_ram #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest0),
      .readdata(readdata0), .inst_input(inst_input), .inst_addr(inst_addr),
      .instruction(instruction), .protocol_err(protocol_err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      inst_input = 1'b1; inst_addr = a; instruction = d;
      @(negedge clk);
      inst_input = 1'b0;
   endtask

   // Full transfer on the WAIT_CYCLES=2 instance: stall, stall, complete, then release.
   task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp, input string tag);
      @(negedge clk);
      read = r; write = w; address = a; writedata = wd; byteenable = be;
      #1 chk({tag, "_wr0"}, waitrequest, 1);
      chk({tag, "_rd0"}, readdata, 0);
      @(negedge clk);
      #1 chk({tag, "_wr1"}, waitrequest, 1);
      chk({tag, "_rd1"}, readdata, 0);
      @(negedge clk);
      #1 chk({tag, "_wr2"}, waitrequest, 0);
      chk({tag, "_rd2"}, readdata, exp);
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      #1 chk({tag, "_idle"}, waitrequest, 0);
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
      inst_input = 1'b0; inst_addr = '0; instruction = '0;
      #1 chk("rst_wait", waitrequest, 0);
      chk("rst_rdata", readdata, 0);
      chk("rst_perr", protocol_err, 0);
      @(negedge clk);
      reset = 1'b0;
      preload(8'h04, 32'h2404FEDC);
      preload(8'h08, 32'h11111111);
      preload(8'h0C, 32'h22222222);
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h2404FEDC, "read04");
      xfer(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, "write10");
      xfer(1, 0, 32'h10, 0, 4'h0, 32'h00BB00DD, "read10");
      xfer(0, 1, 32'h04, 32'hFFFFFFFF, 4'h0, 0, "write_be0");
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h2404FEDC, "read_be0");
      xfer(1, 0, 32'h107, 0, 4'h0, 32'h2404FEDC, "alias107");
      xfer(1, 0, 32'hFFFFFF10, 0, 4'h0, 32'h00BB00DD, "aliasFF10");
      // A held read is two back-to-back transfers, each fully stalled.
      @(negedge clk);
      read = 1'b1; address = 32'h08;
      for (int i = 0; i < 6; i++) begin
         #1 chk($sformatf("held_wr%0d", i), waitrequest, (i % 3 == 2) ? 1'b0 : 1'b1);
         chk($sformatf("held_rd%0d", i), readdata, (i % 3 == 2) ? 32'h11111111 : 32'h0);
         @(negedge clk);
      end
      read = 1'b0;
      @(negedge clk);
      // Zero-wait instance: back-to-back reads complete every cycle.
      read = 1'b1; address = 32'h08;
      #1 chk("zw_wr08", waitrequest0, 0);
      chk("zw_rd08", readdata0, 32'h11111111);
      @(negedge clk);
      address = 32'h0C;
      #1 chk("zw_wr0C", waitrequest0, 0);
      chk("zw_rd0C", readdata0, 32'h22222222);
      @(negedge clk);
      read = 1'b0;
      @(negedge clk);
      // Preload and bus write hit the same word on the ACK edge: preload wins.
      @(negedge clk);
      write = 1'b1; address = 32'h30; writedata = 32'hDEADBEEF; byteenable = 4'hF;
      @(negedge clk);
      @(negedge clk);
      inst_input = 1'b1; inst_addr = 8'h30; instruction = 32'hCAFEF00D;
      #1 chk("coll_ack", waitrequest, 0);
      @(negedge clk);
      write = 1'b0; inst_input = 1'b0;
      xfer(1, 0, 32'h30, 0, 4'h0, 32'hCAFEF00D, "coll_read");
      // Write abandoned mid-WAIT: empty ACK, memory untouched.
      @(negedge clk);
      write = 1'b1; address = 32'h04; writedata = 32'h0; byteenable = 4'hF;
      @(negedge clk);
      write = 1'b0;
      #1 chk("drop_wait", waitrequest, 1);
      @(negedge clk);
      #1 chk("drop_ack_wr", waitrequest, 0);
      chk("drop_ack_rd", readdata, 0);
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h2404FEDC, "drop_read");
      // Read held while preload is active: 3 preload stalls plus 2 normal stalls.
      @(negedge clk);
      read = 1'b1; address = 32'h40; inst_input = 1'b1; inst_addr = 8'h40; instruction = 32'h55AA55AA;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) inst_input = 1'b0;
         #1 chk($sformatf("pl_wr%0d", i), waitrequest, 1);
         chk($sformatf("pl_rd%0d", i), readdata, 0);
         @(negedge clk);
      end
      #1 chk("pl_ack_wr", waitrequest, 0);
      chk("pl_ack_rd", readdata, 32'h55AA55AA);
      @(negedge clk);
      read = 1'b0;
      // Read and write together: no stall, sticky error, memory unchanged.
      @(negedge clk);
      read = 1'b1; write = 1'b1; address = 32'h04; writedata = 32'h0; byteenable = 4'hF;
      #1 chk("both_wait", waitrequest, 0);
      chk("both_perr0", protocol_err, 0);
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      #1 chk("both_perr1", protocol_err, 1);
      @(negedge clk);
      #1 chk("both_perr2", protocol_err, 1);
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h2404FEDC, "both_read");
      chk("both_perr3", protocol_err, 1);
      // Reset during WAIT aborts the write and clears everything.
      @(negedge clk);
      write = 1'b1; address = 32'h20; writedata = 32'h12345678; byteenable = 4'hF;
      #1 chk("rw_wr0", waitrequest, 1);
      @(negedge clk);
      #1 chk("rw_wr1", waitrequest, 1);
      #1 reset = 1'b1;
      #1 chk("rw_rst_wait", waitrequest, 0);
      chk("rw_rst_rdata", readdata, 0);
      chk("rw_rst_perr", protocol_err, 0);
      @(negedge clk);
      write = 1'b0; reset = 1'b0;
      xfer(1, 0, 32'h20, 0, 4'h0, 32'h0, "rw_read20");
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h0, "rw_read04");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/avalon_wait_ram.md
AVALON_WAIT_RAM -- requirements
Module: avalon_wait_ram

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of stall cycles per bus transfer (legal range 0..15).
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words; word index = address[7:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  32  Avalon byte address from CPU master.
REQ-006 read  input  1  Avalon read request.
REQ-007 write  input  1  Avalon write request.
REQ-008 writedata  input  32  Avalon write data.
REQ-009 byteenable  input  4  lane enables; bit n covers writedata[8n+7:8n].
REQ-010 waitrequest  output  1  stall; master SHALL hold all request signals while high.
REQ-011 readdata  output  32  read data; valid only in the completing cycle of a read.
REQ-012 inst_input  input  1  preload enable from bench.
REQ-013 inst_addr  input  8  preload byte address; word index = inst_addr[7:2].
REQ-014 instruction  input  32  preload data word.
REQ-015 protocol_err  output  1  sticky flag: read and write asserted together.

Function
REQ-016 FSM states: IDLE, WAIT, ACK.
REQ-017 IDLE with exactly one of read/write high and inst_input low: WAIT_CYCLES>0 -> waitrequest=1 combinationally that cycle, load counter with WAIT_CYCLES-1, go WAIT; WAIT_CYCLES=0 -> transfer completes in the same cycle (ACK behaviour), stay IDLE.
REQ-018 WAIT: waitrequest=1; counter decrements each cycle; at counter 0 go ACK; total stall = WAIT_CYCLES cycles.
REQ-019 ACK: waitrequest=0; read -> readdata=mem[address[7:2]]; write -> enabled byte lanes of mem[address[7:2]] updated at that clock edge; next state IDLE.
REQ-020 readdata SHALL be 0 in every cycle other than a read-completing cycle.
REQ-021 A request still asserted in IDLE after ACK is a new transfer with full WAIT_CYCLES stall.
REQ-022 address[1:0] and address[31:8] ignored (aliasing/wrap-around, no error).
REQ-023 byteenable=0 write completes the handshake with no memory change.
REQ-024 read and write both high in IDLE: no transfer, waitrequest=0, protocol_err set to 1 until reset.
REQ-025 inst_input high: mem[inst_addr[7:2]] <= instruction each clock edge (full word); bus requests in IDLE stall with waitrequest=1 and FSM stays IDLE.
REQ-026 inst_input asserted while in WAIT/ACK: current transfer proceeds; on same-word same-edge collision, preload data wins.
REQ-027 read and write deasserted mid-WAIT (protocol violation): FSM still runs to ACK; ACK performs no write, readdata=0.

Reset
REQ-028 reset asserted: immediately state=IDLE, counter=0, waitrequest=0, readdata=0, protocol_err=0, all memory words=0.
REQ-029 reset mid-transfer aborts it; a pending write SHALL NOT modify memory.
REQ-030 First transfer accepted on the first rising edge after reset deasserts.

Verification
REQ-031 Preload word 0x04=0x2404FEDC, then read 0x04 (WAIT_CYCLES=2) -> waitrequest high exactly 2 cycles, then readdata=0x2404FEDC for 1 cycle.
REQ-032 Write 0xAABBCCDD to 0x10 byteenable=0b0101 over zeroed word, read back -> 0x00BB00DD.
REQ-033 WAIT_CYCLES=0 build: back-to-back reads 0x08, 0x0C -> waitrequest never high, data each cycle.
REQ-034 read=write=1 in IDLE -> waitrequest=0, protocol_err=1, memory unchanged; stays 1 until reset.
REQ-035 Write 0x12345678 to 0x20, reset asserted during WAIT -> outputs 0 immediately; read 0x20 after reset -> 0x00000000.
REQ-036 Read request in IDLE with inst_input=1 for 3 cycles -> waitrequest=1 for those 3 cycles plus 2, then data returned.
